// File: rtl/rv_pkg.sv
// Core-wide constants shared by the RV32 SoC: data width and the UART data-memory address.
package rv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] ADDRESS_UART = 32'h1000_0000;
endpackage

// File: rtl/rv_uart_arbiter_pkg.sv
// Types and sizes shared by the UART arbiter and its per-port capture block.
package rv_uart_arbiter_pkg;
    import rv_pkg::*;

    localparam int NUM_PORTS = 2;
    localparam int BE_W      = XLEN / 8;

    typedef struct packed {
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } uart_txn_t;
endpackage

// File: rtl/rv_uart_arb_port.sv
// Per-port capture stage: latches one UART request, holds it until the arbiter
// clears it, and flags any request that arrives while one is still outstanding.
module rv_uart_arb_port
    import rv_pkg::*;
    import rv_uart_arbiter_pkg::*;
#(
    parameter logic [XLEN-1:0] UART_ADDR = ADDRESS_UART
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            req,
    input  logic            we,
    input  logic [BE_W-1:0] be,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            clr,
    output logic            pend,
    output logic            hold_we,
    output logic [BE_W-1:0] hold_be,
    output logic [XLEN-1:0] hold_addr,
    output logic [XLEN-1:0] hold_wdata,
    output logic            overrun
);

    uart_txn_t hold_reg;
    logic      pend_reg;
    logic      overrun_reg;
    logic      hit;
    logic      accept;

    assign hit    = req && (addr == UART_ADDR);
    // A request landing in the response cycle refills the slot instead of overrunning.
    assign accept = hit && (!pend_reg || clr);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            hold_reg    <= '0;
            pend_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (accept) begin
                hold_reg <= '{we: we, be: be, addr: addr, wdata: wdata};
            end
            pend_reg <= accept || (pend_reg && !clr);
            if (hit && pend_reg && !clr) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign pend       = pend_reg;
    assign overrun    = overrun_reg;
    assign hold_we    = hold_reg.we;
    assign hold_be    = hold_reg.be;
    assign hold_addr  = hold_reg.addr;
    assign hold_wdata = hold_reg.wdata;

endmodule

// File: rtl/rv_uart_arbiter.sv
// Round-robin arbiter sharing the single UART slave between the LSU (port 0)
// and the debug/loader master (port 1); one transaction in flight at a time.
module rv_uart_arbiter
    import rv_pkg::*;
    import rv_uart_arbiter_pkg::*;
#(
    parameter logic [XLEN-1:0] UART_ADDR = ADDRESS_UART
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [XLEN/8-1:0] m0_be_i,
    input  logic [XLEN-1:0]   m0_addr_i,
    input  logic [XLEN-1:0]   m0_wdata_i,
    output logic              m0_rvalid_o,
    output logic [XLEN-1:0]   m0_rdata_o,
    output logic              m0_busy_o,
    output logic              m0_overrun_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [XLEN/8-1:0] m1_be_i,
    input  logic [XLEN-1:0]   m1_addr_i,
    input  logic [XLEN-1:0]   m1_wdata_i,
    output logic              m1_rvalid_o,
    output logic [XLEN-1:0]   m1_rdata_o,
    output logic              m1_busy_o,
    output logic              m1_overrun_o,
    output logic              s_req_o,
    output logic              s_we_o,
    output logic [XLEN/8-1:0] s_be_o,
    output logic [XLEN-1:0]   s_addr_o,
    output logic [XLEN-1:0]   s_wdata_o,
    input  logic              s_rvalid_i,
    input  logic [XLEN-1:0]   s_rdata_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [NUM_PORTS-1:0] req_vec, we_vec, clr_vec, pend_vec, ovr_vec, rvalid_vec;
    logic [BE_W-1:0]      be_arr         [NUM_PORTS];
    logic [XLEN-1:0]      addr_arr       [NUM_PORTS];
    logic [XLEN-1:0]      wdata_arr      [NUM_PORTS];
    logic [NUM_PORTS-1:0] hold_we_vec;
    logic [BE_W-1:0]      hold_be_arr    [NUM_PORTS];
    logic [XLEN-1:0]      hold_addr_arr  [NUM_PORTS];
    logic [XLEN-1:0]      hold_wdata_arr [NUM_PORTS];
    logic [XLEN-1:0]      rdata_arr      [NUM_PORTS];

    logic [1:0]      state_reg, state_next;
    logic            owner_reg, owner_next;
    logic            last_gnt_reg, last_gnt_next;
    logic [XLEN-1:0] rdata_reg, rdata_next;
    uart_txn_t       s_txn_reg, s_txn_next;

    assign req_vec      = {m1_req_i, m0_req_i};
    assign we_vec       = {m1_we_i, m0_we_i};
    assign be_arr[0]    = m0_be_i;
    assign be_arr[1]    = m1_be_i;
    assign addr_arr[0]  = m0_addr_i;
    assign addr_arr[1]  = m1_addr_i;
    assign wdata_arr[0] = m0_wdata_i;
    assign wdata_arr[1] = m1_wdata_i;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            rv_uart_arb_port #(
                .UART_ADDR (UART_ADDR)
            ) u_port (
                .clk_i      (clk_i),
                .arstn_i    (arstn_i),
                .req        (req_vec[gi]),
                .we         (we_vec[gi]),
                .be         (be_arr[gi]),
                .addr       (addr_arr[gi]),
                .wdata      (wdata_arr[gi]),
                .clr        (clr_vec[gi]),
                .pend       (pend_vec[gi]),
                .hold_we    (hold_we_vec[gi]),
                .hold_be    (hold_be_arr[gi]),
                .hold_addr  (hold_addr_arr[gi]),
                .hold_wdata (hold_wdata_arr[gi]),
                .overrun    (ovr_vec[gi])
            );

            assign clr_vec[gi]    = (state_reg == ST_RESP) && (owner_reg == 1'(gi));
            assign rvalid_vec[gi] = (state_reg == ST_RESP) && (owner_reg == 1'(gi));
            assign rdata_arr[gi]  = rvalid_vec[gi] ? rdata_reg : '0;
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        last_gnt_next = last_gnt_reg;
        rdata_next    = rdata_reg;
        s_txn_next    = s_txn_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|pend_vec) begin
                    // Tie goes to the port that was not served last.
                    owner_next = (&pend_vec) ? ~last_gnt_reg : pend_vec[1];
                    s_txn_next = '{we:    hold_we_vec[owner_next],
                                   be:    hold_be_arr[owner_next],
                                   addr:  hold_addr_arr[owner_next],
                                   wdata: hold_wdata_arr[owner_next]};
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (s_rvalid_i) begin
                    rdata_next = s_rdata_i;
                    state_next = ST_RESP;
                end
            end
            default: begin
                last_gnt_next = owner_reg;
                state_next    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= 1'b0;
            last_gnt_reg <= 1'b1;
            rdata_reg    <= '0;
            s_txn_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            last_gnt_reg <= last_gnt_next;
            rdata_reg    <= rdata_next;
            s_txn_reg    <= s_txn_next;
        end
    end

    assign s_req_o   = (state_reg == ST_ISSUE);
    assign s_we_o    = s_txn_reg.we;
    assign s_be_o    = s_txn_reg.be;
    assign s_addr_o  = s_txn_reg.addr;
    assign s_wdata_o = s_txn_reg.wdata;

    assign m0_rvalid_o  = rvalid_vec[0];
    assign m1_rvalid_o  = rvalid_vec[1];
    assign m0_rdata_o   = rdata_arr[0];
    assign m1_rdata_o   = rdata_arr[1];
    assign m0_busy_o    = pend_vec[0];
    assign m1_busy_o    = pend_vec[1];
    assign m0_overrun_o = ovr_vec[0];
    assign m1_overrun_o = ovr_vec[1];

endmodule

// File: tb/tb_rv_uart_arbiter.sv
// Scoreboard bench for rv_uart_arbiter: a transaction-level model predicts grants,
// payloads, busy/overrun flags and routed responses; a negedge monitor compares.
module tb_rv_uart_arbiter;
    import rv_pkg::*;

    localparam logic [31:0] UA = ADDRESS_UART;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arstn_i = 1'b1;
    logic [1:0]  drv_req = '0;
    logic [1:0]  drv_we  = '0;
    logic [3:0]  drv_be    [2];
    logic [31:0] drv_addr  [2];
    logic [31:0] drv_wdata [2];

    logic        m0_rvalid_o, m1_rvalid_o, m0_busy_o, m1_busy_o, m0_overrun_o, m1_overrun_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic        s_rvalid_i = 1'b0;
    logic [31:0] s_rdata_i  = '0;

    rv_uart_arbiter #(.UART_ADDR(UA)) dut (
        .clk_i        (clk),
        .arstn_i      (arstn_i),
        .m0_req_i     (drv_req[0]),
        .m0_we_i      (drv_we[0]),
        .m0_be_i      (drv_be[0]),
        .m0_addr_i    (drv_addr[0]),
        .m0_wdata_i   (drv_wdata[0]),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_rdata_o   (m0_rdata_o),
        .m0_busy_o    (m0_busy_o),
        .m0_overrun_o (m0_overrun_o),
        .m1_req_i     (drv_req[1]),
        .m1_we_i      (drv_we[1]),
        .m1_be_i      (drv_be[1]),
        .m1_addr_i    (drv_addr[1]),
        .m1_wdata_i   (drv_wdata[1]),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_rdata_o   (m1_rdata_o),
        .m1_busy_o    (m1_busy_o),
        .m1_overrun_o (m1_overrun_o),
        .s_req_o      (s_req_o),
        .s_we_o       (s_we_o),
        .s_be_o       (s_be_o),
        .s_addr_o     (s_addr_o),
        .s_wdata_o    (s_wdata_o),
        .s_rvalid_i   (s_rvalid_i),
        .s_rdata_i    (s_rdata_i)
    );

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stamp;
        bit          issued;
    } mtxn_t;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    mtxn_t       mtx   [2];
    bit          mvalid    [2];
    bit          movr      [2];
    bit          resp_seen [2];
    logic [31:0] last_rdata [2];
    int          last_gnt  = 1;
    int          inflight  = -1;
    exp_t        exp_q [$];
    logic [31:0] issue_log [$];
    int          slave_cnt   = 0;
    int          force_lat   = 0;
    bit          force_rd_en = 1'b0;
    logic [31:0] force_rd    = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: each port holds at most one accepted transaction.
    always @(posedge clk) begin
        if (arstn_i) begin
            cyc++;
            for (int p = 0; p < 2; p++) begin
                bit hit;
                bit was_busy;
                hit      = drv_req[p] && (drv_addr[p] == UA);
                was_busy = mvalid[p];
                if (resp_seen[p]) mvalid[p] = 1'b0;
                if (hit && (!was_busy || resp_seen[p])) begin
                    mtx[p]    = '{we: drv_we[p], be: drv_be[p], addr: drv_addr[p],
                                  wdata: drv_wdata[p], stamp: cyc, issued: 1'b0};
                    mvalid[p] = 1'b1;
                end else if (hit) begin
                    movr[p] = 1'b1;
                end
                resp_seen[p] = 1'b0;
            end
        end
    end

    // Monitor plus slave responder, all sampled away from the active edge.
    always @(negedge clk) begin
        logic [1:0]  rv;
        logic [31:0] rd [2];
        bit          c0, c1;
        int          c;
        logic [31:0] d;
        rv    = {m1_rvalid_o, m0_rvalid_o};
        rd[0] = m0_rdata_o;
        rd[1] = m1_rdata_o;
        if (!arstn_i) begin
            check("reset_outputs_zero",
                  64'(|{m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o, m0_busy_o, m1_busy_o,
                        m0_overrun_o, m1_overrun_o, s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o}),
                  64'd0);
        end else begin
            s_rvalid_i = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (rv[p]) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rvalid: port %0d rvalid=1, expected no response", p);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("rsp_port", 64'(p), 64'(e.port));
                        check("rsp_data", 64'(rd[p]), 64'(e.data));
                        last_gnt = e.port;
                    end
                    last_rdata[p] = rd[p];
                    resp_seen[p]  = 1'b1;
                    inflight      = -1;
                end else begin
                    check("rdata_zero_idle", 64'(rd[p]), 64'd0);
                end
            end
            check("busy0", 64'(m0_busy_o), 64'(mvalid[0]));
            check("busy1", 64'(m1_busy_o), 64'(mvalid[1]));
            check("overrun0", 64'(m0_overrun_o), 64'(movr[0]));
            check("overrun1", 64'(m1_overrun_o), 64'(movr[1]));

            if (slave_cnt > 0) begin
                slave_cnt--;
                if (slave_cnt == 0) begin
                    d = force_rd_en ? force_rd : $urandom;
                    s_rvalid_i = 1'b1;
                    s_rdata_i  = d;
                    exp_q.push_back('{port: inflight, data: d});
                end
            end else if (inflight == -1 && $urandom_range(7) == 0) begin
                // Stray response outside WAIT must be ignored.
                s_rvalid_i = 1'b1;
                s_rdata_i  = $urandom;
            end

            if (s_req_o) begin
                if (inflight != -1) begin
                    total++;
                    bad++;
                    $display("FAIL dup_issue: s_req_o=1 while port %0d in flight, expected 0", inflight);
                end
                c0 = mvalid[0] && !mtx[0].issued && (mtx[0].stamp < cyc);
                c1 = mvalid[1] && !mtx[1].issued && (mtx[1].stamp < cyc);
                if (!c0 && !c1) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: s_req_o=1 wdata=0x%0h, expected no request", s_wdata_o);
                end else begin
                    c = (c0 && c1) ? ((last_gnt == 0) ? 1 : 0) : (c1 ? 1 : 0);
                    check("issue_payload", {s_we_o, s_be_o, s_addr_o, s_wdata_o[26:0]},
                          {mtx[c].we, mtx[c].be, mtx[c].addr, mtx[c].wdata[26:0]});
                    check("issue_wdata_hi", 64'(s_wdata_o[31:27]), 64'(mtx[c].wdata[31:27]));
                    mtx[c].issued = 1'b1;
                    inflight      = c;
                    issue_log.push_back(s_wdata_o);
                    slave_cnt = (force_lat > 0) ? force_lat : int'($urandom_range(6, 1));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        drv_req = '0;
    endtask

    task automatic send(input int p, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        drv_req[p]   = 1'b1;
        drv_we[p]    = we;
        drv_be[p]    = 4'($urandom);
        drv_addr[p]  = addr;
        drv_wdata[p] = wd;
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk);
        #1;
        arstn_i    = 1'b0;
        drv_req    = '0;
        s_rvalid_i = 1'b0;
        slave_cnt  = 0;
        inflight   = -1;
        last_gnt   = 1;
        exp_q.delete();
        for (int p = 0; p < 2; p++) begin
            mvalid[p]    = 1'b0;
            movr[p]      = 1'b0;
            resp_seen[p] = 1'b0;
        end
        repeat (ncyc) @(posedge clk);
        #1;
        arstn_i = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mvalid[0] || mvalid[1] || inflight != -1 || exp_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
        end
        repeat (3) tick();
    endtask

    initial begin
        int base;
        int n;
        for (int p = 0; p < 2; p++) begin
            drv_be[p] = '0; drv_addr[p] = '0; drv_wdata[p] = '0;
            mvalid[p] = 1'b0; movr[p] = 1'b0; resp_seen[p] = 1'b0; last_rdata[p] = '0;
        end
        do_reset(2);
        tick();

        force_lat = 5;
        send(0, 1'b1, UA, 32'h41);
        tick();
        wait_idle();
        check("single_write_wdata", 64'(issue_log[issue_log.size()-1]), 64'h41);
        force_lat = 0;

        force_rd_en = 1'b1;
        force_rd    = 32'h5A;
        send(1, 1'b0, UA, $urandom);
        tick();
        wait_idle();
        check("read_m1_rdata", 64'(last_rdata[1]), 64'h5A);
        force_rd_en = 1'b0;

        for (int r = 0; r < 2; r++) begin
            base = issue_log.size();
            send(0, 1'b1, UA, 32'h11);
            send(1, 1'b1, UA, 32'h22);
            tick();
            wait_idle();
            check("contend_count", 64'(issue_log.size() - base), 64'd2);
            if (issue_log.size() >= base + 2) begin
                check("contend_first", 64'(issue_log[base]), 64'h11);
                check("contend_second", 64'(issue_log[base+1]), 64'h22);
            end
        end

        base = issue_log.size();
        send(0, 1'b1, UA, 32'h61);
        tick();
        send(1, 1'b1, UA, 32'h62);
        tick();
        n = 0;
        while (!m0_rvalid_o && n < 500) begin
            tick();
            n++;
        end
        send(0, 1'b1, UA, 32'h63);
        tick();
        wait_idle();
        check("refill_count", 64'(issue_log.size() - base), 64'd3);
        if (issue_log.size() >= base + 3) begin
            check("refill_order0", 64'(issue_log[base]), 64'h61);
            check("refill_order1", 64'(issue_log[base+1]), 64'h62);
            check("refill_order2", 64'(issue_log[base+2]), 64'h63);
        end
        check("refill_no_overrun", 64'(m0_overrun_o), 64'd0);

        base = issue_log.size();
        send(0, 1'b1, UA, 32'h77);
        tick();
        send(0, 1'b1, UA, 32'h78);
        tick();
        wait_idle();
        check("overrun_set", 64'(m0_overrun_o), 64'd1);
        check("overrun_one_issue", 64'(issue_log.size() - base), 64'd1);

        base = issue_log.size();
        send(1, 1'b1, UA + 32'd4, 32'h99);
        tick();
        repeat (6) tick();
        check("filter_no_issue", 64'(issue_log.size() - base), 64'd0);
        check("filter_busy", 64'(m1_busy_o), 64'd0);
        check("filter_overrun", 64'(m1_overrun_o), 64'd0);

        force_lat = 20;
        send(0, 1'b0, UA, 32'h0);
        tick();
        n = 0;
        while (inflight == -1 && n < 50) begin
            tick();
            n++;
        end
        repeat (2) tick();
        do_reset(2);
        force_lat = 0;
        tick();
        check("post_reset_busy", 64'(m0_busy_o), 64'd0);
        check("post_reset_overrun", 64'(m0_overrun_o), 64'd0);
        send(0, 1'b1, UA, 32'h33);
        tick();
        wait_idle();
        check("post_reset_write", 64'(issue_log[issue_log.size()-1]), 64'h33);

        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(3) == 0) begin
                    send(p, 1'($urandom), ($urandom_range(5) == 0) ? UA + 32'd4 : UA, $urandom);
                end
            end
            tick();
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
